lcd_bus_writer: RTL and testbench

LCD_BUS_WRITER -- requirements
Module: lcd_bus_writer

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_fifo.sv | 77 +++++++
 rtl/lcd_bus_writer.sv | 239 +++++++++++++++++++++++
 tb/tb_lcd_bus_writer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the LCD parallel bus writer.
//   - lcd_state_t : bus FSM states
//   - panel command/data constants used by the power-up sequence
//   - rom_entry_t : one power-up ROM step {kind, value}
//   - init_rom()  : the power-up ROM itself
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_INIT_WAIT = 3'd0,
    ST_INIT_LOAD = 3'd1,
    ST_IDLE      = 3'd2,
    ST_LOAD      = 3'd3,
    ST_WR_LOW    = 3'd4,
    ST_WR_HIGH   = 3'd5
  } lcd_state_t;

  localparam logic [7:0] CMD_SWRESET   = 8'h01;
  localparam logic [7:0] CMD_SLPOUT    = 8'h11;
  localparam logic [7:0] CMD_COLMOD    = 8'h3A;
  localparam logic [7:0] DAT_COLMOD_16 = 8'h55;
  localparam logic [7:0] CMD_DISPON    = 8'h29;

  typedef enum logic [1:0] {
    RK_WAIT = 2'd0,
    RK_CMD  = 2'd1,
    RK_DATA = 2'd2
  } rom_kind_t;

  typedef struct packed {
    rom_kind_t  kind;
    logic [7:0] value;
  } rom_entry_t;

  // For WAIT entries the value selects which delay to apply.
  localparam logic [7:0] WAIT_SEL_RST   = 8'h00;
  localparam logic [7:0] WAIT_SEL_SLEEP = 8'h01;

  localparam logic [2:0] ROM_LAST_IDX = 3'd7;

  function automatic rom_entry_t init_rom(input logic [2:0] idx);
    rom_entry_t e;
    case (idx)
      3'd0:    e = '{kind: RK_WAIT, value: WAIT_SEL_RST};
      3'd1:    e = '{kind: RK_CMD,  value: CMD_SWRESET};
      3'd2:    e = '{kind: RK_WAIT, value: WAIT_SEL_SLEEP};
      3'd3:    e = '{kind: RK_CMD,  value: CMD_SLPOUT};
      3'd4:    e = '{kind: RK_WAIT, value: WAIT_SEL_SLEEP};
      3'd5:    e = '{kind: RK_CMD,  value: CMD_COLMOD};
      3'd6:    e = '{kind: RK_DATA, value: DAT_COLMOD_16};
      default: e = '{kind: RK_CMD,  value: CMD_DISPON};
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lcd_fifo.sv
// lcd_fifo: small synchronous first-in first-out buffer.
//   clk, rst_n          : clock, asynchronous active-low reset
//   push, push_data     : write request (ignored when full)
//   pop                 : read request (ignored when empty)
//   pop_data            : head entry (valid while !empty)
//   full, empty         : registered occupancy flags
module lcd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_r;
  logic             empty_r;
  logic             do_push_s;
  logic             do_pop_s;
  logic [CW-1:0]    count_nxt_s;

  // Qualify requests against the flags and compute the next occupancy.
  always_comb begin
    do_push_s   = push & ~full_r;
    do_pop_s    = pop & ~empty_r;
    count_nxt_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_nxt_s = count_r + CW'(1);
      2'b01:   count_nxt_s = count_r - CW'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Storage, pointers and registered occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= (wr_ptr_r == PTR_LAST) ? '0 : wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_LAST) ? '0 : rd_ptr_r + AW'(1);
      end
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == CNT_FULL);
      empty_r <= (count_nxt_s == '0);
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = full_r;
  assign empty    = empty_r;

endmodule

// File: rtl/lcd_bus_writer.sv
// lcd_bus_writer: drives an 8080-style LCD parallel bus (D, dcx, wr).
// After reset it plays a fixed power-up sequence, then forwards bytes
// queued in a 4-entry FIFO. Each byte: 1 load cycle, WR_LOW_CYC cycles
// with wr low, WR_HIGH_CYC cycles with wr high (panel latches on rise).
//   hwclk, reset          : clock, asynchronous active-low reset
//   in_valid/in_dcx/in_data/in_ready : upstream byte handshake
//   dcx, wr, D            : panel bus
//   init_done             : power-up sequence finished
//   busy                  : write in progress or FIFO non-empty
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int WR_LOW_CYC     = 2,
  parameter int WR_HIGH_CYC    = 2,
  parameter int RST_WAIT_CYC   = 1200,
  parameter int SLEEP_WAIT_CYC = 1_200_000
) (
  input  logic       hwclk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic       in_dcx,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       dcx,
  output logic       wr,
  output logic [7:0] D,
  output logic       init_done,
  output logic       busy
);

  localparam int MAX_WAIT = (RST_WAIT_CYC > SLEEP_WAIT_CYC) ? RST_WAIT_CYC : SLEEP_WAIT_CYC;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] RST_WAIT_LAST   = WAIT_W'(RST_WAIT_CYC - 1);
  localparam logic [WAIT_W-1:0] SLEEP_WAIT_LAST = WAIT_W'(SLEEP_WAIT_CYC - 1);
  localparam logic [3:0]        LOW_LAST        = 4'(WR_LOW_CYC - 1);
  localparam logic [3:0]        HIGH_LAST       = 4'(WR_HIGH_CYC - 1);

  lcd_state_t        state_r;
  lcd_state_t        state_nxt_s;
  logic [2:0]        rom_idx_r;
  logic [2:0]        rom_idx_nxt_s;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic [3:0]        phase_cnt_r;
  logic              init_done_r;
  logic              init_done_nxt_s;
  logic              alive_r;
  logic              wr_r;
  logic              dcx_r;
  logic [7:0]        d_r;
  logic              wr_nxt_s;
  logic              dcx_nxt_s;
  logic [7:0]        d_nxt_s;
  logic              push_s;
  logic              pop_s;
  logic [8:0]        fifo_data_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  rom_entry_t        rom_cur_s;
  rom_entry_t        rom_nxt_s;
  logic [WAIT_W-1:0] wait_last_s;
  logic              wait_done_s;
  logic              phase_done_s;
  logic              writing_s;

  assign push_s = in_valid & in_ready;

  lcd_fifo #(
    .DEPTH (4),
    .WIDTH (9)
  ) u_fifo (
    .clk       (hwclk),
    .rst_n     (reset),
    .push      (push_s),
    .push_data ({in_dcx, in_data}),
    .pop       (pop_s),
    .pop_data  (fifo_data_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s)
  );

  // ROM lookups and end-of-wait / end-of-phase detection.
  // Any step that enters INIT_LOAD advances the ROM index by one, so the
  // byte to load is always the entry after the current one.
  always_comb begin
    rom_cur_s = init_rom(rom_idx_r);
    rom_nxt_s = init_rom(rom_idx_r + 3'd1);
    if (rom_cur_s.value == WAIT_SEL_SLEEP) begin
      wait_last_s = SLEEP_WAIT_LAST;
    end else begin
      wait_last_s = RST_WAIT_LAST;
    end
    wait_done_s = (rom_cur_s.kind == RK_WAIT) && (wait_cnt_r == wait_last_s);
    if (state_r == ST_WR_LOW) begin
      phase_done_s = (phase_cnt_r == LOW_LAST);
    end else begin
      phase_done_s = (phase_cnt_r == HIGH_LAST);
    end
  end

  // FSM state, ROM index and init flag registers.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_INIT_WAIT;
      rom_idx_r   <= 3'd0;
      init_done_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      rom_idx_r   <= rom_idx_nxt_s;
      init_done_r <= init_done_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s     = state_r;
    rom_idx_nxt_s   = rom_idx_r;
    init_done_nxt_s = init_done_r;
    case (state_r)
      ST_INIT_WAIT: begin
        if (wait_done_s) begin
          state_nxt_s   = ST_INIT_LOAD;
          rom_idx_nxt_s = rom_idx_r + 3'd1;
        end else begin
          state_nxt_s = ST_INIT_WAIT;
        end
      end
      ST_INIT_LOAD: state_nxt_s = ST_WR_LOW;
      ST_LOAD:      state_nxt_s = ST_WR_LOW;
      ST_WR_LOW: begin
        if (phase_done_s) begin
          state_nxt_s = ST_WR_HIGH;
        end else begin
          state_nxt_s = ST_WR_LOW;
        end
      end
      ST_WR_HIGH: begin
        if (!phase_done_s) begin
          state_nxt_s = ST_WR_HIGH;
        end else if (init_done_r) begin
          if (!fifo_empty_s) begin
            state_nxt_s = ST_LOAD;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else if (rom_idx_r == ROM_LAST_IDX) begin
          // Last power-up byte: the FIFO is only served once init_done is up.
          state_nxt_s     = ST_IDLE;
          init_done_nxt_s = 1'b1;
        end else begin
          rom_idx_nxt_s = rom_idx_r + 3'd1;
          if (rom_nxt_s.kind == RK_WAIT) begin
            state_nxt_s = ST_INIT_WAIT;
          end else begin
            state_nxt_s = ST_INIT_LOAD;
          end
        end
      end
      ST_IDLE: begin
        if (init_done_r && !fifo_empty_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: state_nxt_s = ST_INIT_WAIT;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with it.
  always_comb begin
    if (state_nxt_s == ST_WR_LOW) begin
      wr_nxt_s = 1'b0;
    end else begin
      wr_nxt_s = 1'b1;
    end
    case (state_nxt_s)
      ST_INIT_LOAD: begin
        d_nxt_s   = rom_nxt_s.value;
        dcx_nxt_s = (rom_nxt_s.kind == RK_DATA);
        pop_s     = 1'b0;
      end
      ST_LOAD: begin
        d_nxt_s   = fifo_data_s[7:0];
        dcx_nxt_s = fifo_data_s[8];
        pop_s     = 1'b1;
      end
      default: begin
        d_nxt_s   = d_r;
        dcx_nxt_s = dcx_r;
        pop_s     = 1'b0;
      end
    endcase
  end

  // Wait and phase counters restart whenever the state changes.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      wait_cnt_r  <= '0;
      phase_cnt_r <= 4'd0;
    end else begin
      if ((state_r == ST_INIT_WAIT) && (state_nxt_s == ST_INIT_WAIT)) begin
        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
      end else begin
        wait_cnt_r <= '0;
      end
      if ((state_nxt_s == state_r) && ((state_r == ST_WR_LOW) || (state_r == ST_WR_HIGH))) begin
        phase_cnt_r <= phase_cnt_r + 4'd1;
      end else begin
        phase_cnt_r <= 4'd0;
      end
    end
  end

  // Output registers; reset forces wr high immediately.
  always_ff @(posedge hwclk or negedge reset) begin
    if (!reset) begin
      wr_r    <= 1'b1;
      dcx_r   <= 1'b0;
      d_r     <= 8'h00;
      alive_r <= 1'b0;
    end else begin
      wr_r    <= wr_nxt_s;
      dcx_r   <= dcx_nxt_s;
      d_r     <= d_nxt_s;
      alive_r <= 1'b1;
    end
  end

  assign writing_s = (state_r == ST_INIT_LOAD) || (state_r == ST_LOAD) ||
                     (state_r == ST_WR_LOW)    || (state_r == ST_WR_HIGH);

  assign in_ready  = alive_r & ~fifo_full_s;
  assign busy      = writing_s | ~fifo_empty_s;
  assign wr        = wr_r;
  assign dcx       = dcx_r;
  assign D         = d_r;
  assign init_done = init_done_r;

endmodule

// File: tb/tb_lcd_bus_writer.sv
// tb_lcd_bus_writer: scoreboard bench for lcd_bus_writer with short waits.
// Expected bus bytes are queued as stimulus is accepted and compared by a
// monitor at every wr rising edge.
module tb_lcd_bus_writer;

  localparam int LOW_C   = 2;
  localparam int HIGH_C  = 2;
  localparam int RST_W   = 4;
  localparam int SLEEP_W = 20;
  localparam int PITCH   = 1 + LOW_C + HIGH_C;

  logic       tb_clk   = 1'b0;
  logic       reset    = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_dcx   = 1'b0;
  logic [7:0] in_data  = 8'h00;
  logic       in_ready;
  logic       dcx;
  logic       wr;
  logic [7:0] D;
  logic       init_done;
  logic       busy;

  always #5 tb_clk = ~tb_clk;

  lcd_bus_writer #(
    .WR_LOW_CYC     (LOW_C),
    .WR_HIGH_CYC    (HIGH_C),
    .RST_WAIT_CYC   (RST_W),
    .SLEEP_WAIT_CYC (SLEEP_W)
  ) dut (
    .hwclk     (tb_clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_dcx    (in_dcx),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .dcx       (dcx),
    .wr        (wr),
    .D         (D),
    .init_done (init_done),
    .busy      (busy)
  );

  int         checks = 0;
  int         failures = 0;
  logic [8:0] sb[$];
  int         rise_q[$];
  int         cyc = 0;
  int         pre_done_rises = 0;
  int         done_falls = 0;
  int         stall_cnt = 0;
  int         accept_cnt = 0;
  int         first_stall_accepts = -1;

  // Bus monitor: every wr rise must latch the next expected byte.
  initial begin
    logic       prev_wr;
    logic       prev_done;
    int         low_cnt;
    logic [8:0] d_before;
    logic [8:0] exp_b;
    prev_wr   = 1'b1;
    prev_done = 1'b0;
    low_cnt   = 0;
    d_before  = 9'h000;
    forever begin
      @(negedge tb_clk);
      cyc++;
      if (!reset) begin
        prev_wr   = 1'b1;
        prev_done = 1'b0;
        low_cnt   = 0;
      end else begin
        if (prev_done && !init_done) done_falls++;
        prev_done = init_done;
        if (wr == 1'b0) begin
          low_cnt++;
          d_before = {dcx, D};
        end
        if (prev_wr == 1'b0 && wr == 1'b1) begin
          rise_q.push_back(cyc);
          if (!init_done) pre_done_rises++;
          checks++;
          if (sb.size() == 0) begin
            failures++;
            $display("FAIL bus_unexpected: got dcx/D=%h, want no write", {dcx, D});
          end else begin
            exp_b = sb.pop_front();
            if ({dcx, D} !== exp_b) begin
              failures++;
              $display("FAIL bus_byte: got dcx/D=%h, want %h", {dcx, D}, exp_b);
            end
          end
          checks++;
          if (low_cnt != LOW_C) begin
            failures++;
            $display("FAIL wr_low_width: got %0d, want %0d", low_cnt, LOW_C);
          end
          checks++;
          if ({dcx, D} !== d_before) begin
            failures++;
            $display("FAIL bus_stable: got %h after rise, want %h", {dcx, D}, d_before);
          end
          low_cnt = 0;
        end
        prev_wr = wr;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge tb_clk);
    #1;
  endtask

  task automatic push_init_expect();
    sb.push_back({1'b0, 8'h01});
    sb.push_back({1'b0, 8'h11});
    sb.push_back({1'b0, 8'h3A});
    sb.push_back({1'b1, 8'h55});
    sb.push_back({1'b0, 8'h29});
  endtask

  task automatic push_byte(input logic c, input logic [7:0] v);
    bit ok;
    bit rdy;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_dcx   = c;
    in_data  = v;
    for (int k = 0; k < 200; k++) begin
      rdy = in_ready;
      @(posedge tb_clk);
      if (rdy) begin
        ok = 1'b1;
        sb.push_back({c, v});
        accept_cnt++;
      end else begin
        stall_cnt++;
        if (first_stall_accepts < 0) first_stall_accepts = accept_cnt;
      end
      step();
      if (ok) break;
    end
    in_valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL push_accept: got no accept, want accept of %h", {c, v});
    end
  endtask

  task automatic wait_init_done(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (init_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL init_done_timeout: got init_done=%b, want 1", init_done);
    end
  endtask

  task automatic wait_drained(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 600; k++) begin
      if (sb.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_drain: got %0d pending busy=%b, want 0 pending idle", name, sb.size(), busy);
    end
  endtask

  task automatic check_pitch(input string name);
    int bad;
    bad = 0;
    for (int i = 1; i < rise_q.size(); i++) begin
      if (rise_q[i] - rise_q[i-1] != PITCH) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_pitch: got %0d off-pitch gaps, want 0 (pitch %0d)", name, bad, PITCH);
    end
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (3) step();
    checks++; if (wr !== 1'b1)        begin failures++; $display("FAIL reset_wr: got %b want 1", wr); end
    checks++; if (dcx !== 1'b0)       begin failures++; $display("FAIL reset_dcx: got %b want 0", dcx); end
    checks++; if (D !== 8'h00)        begin failures++; $display("FAIL reset_d: got %h want 00", D); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done: got %b want 0", init_done); end
    checks++; if (busy !== 1'b0)      begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0)  begin failures++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    sb.delete();
    rise_q.delete();
    pre_done_rises = 0;
    push_init_expect();
    reset = 1'b1;
    @(posedge tb_clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin failures++; $display("FAIL release_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_init();
    bit ok;
    wait_init_done(ok);
    if (ok) begin
      checks++;
      if (rise_q.size() != 5) begin
        failures++;
        $display("FAIL init_writes: got %0d, want 5", rise_q.size());
      end else begin
        checks++;
        if (cyc - rise_q[4] != HIGH_C) begin
          failures++;
          $display("FAIL init_done_timing: got %0d cycles after last rise, want %0d", cyc - rise_q[4], HIGH_C);
        end
        checks++;
        if (rise_q[1] - rise_q[0] < SLEEP_W || rise_q[2] - rise_q[1] < SLEEP_W) begin
          failures++;
          $display("FAIL init_sleep_gap: got %0d/%0d, want >= %0d", rise_q[1] - rise_q[0], rise_q[2] - rise_q[1], SLEEP_W);
        end
        checks++;
        if (rise_q[3] - rise_q[2] != PITCH || rise_q[4] - rise_q[3] != PITCH) begin
          failures++;
          $display("FAIL init_tail_pitch: got %0d/%0d, want %0d", rise_q[3] - rise_q[2], rise_q[4] - rise_q[3], PITCH);
        end
      end
    end
    repeat (10) step();
    checks++;
    if (init_done !== 1'b1 || done_falls != 0) begin
      failures++;
      $display("FAIL init_done_sticky: got init_done=%b falls=%0d, want 1 and 0", init_done, done_falls);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_basic();
    wait_drained("pre_basic");
    rise_q.delete();
    push_byte(1'b0, 8'h2C);
    push_byte(1'b1, 8'hF8);
    push_byte(1'b1, 8'h00);
    wait_drained("basic");
    checks++;
    if (rise_q.size() != 3) begin
      failures++;
      $display("FAIL basic_writes: got %0d, want 3", rise_q.size());
    end
    check_pitch("basic");
    checks++;
    if (D !== 8'h00 || dcx !== 1'b1) begin
      failures++;
      $display("FAIL basic_hold: got dcx/D=%b/%h, want 1/00", dcx, D);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] vals [6];
    vals[0] = 8'h10; vals[1] = 8'h21; vals[2] = 8'h32;
    vals[3] = 8'h43; vals[4] = 8'h54; vals[5] = 8'h65;
    wait_drained("pre_b2b");
    rise_q.delete();
    stall_cnt           = 0;
    accept_cnt          = 0;
    first_stall_accepts = -1;
    for (int i = 0; i < 6; i++) begin
      push_byte(i[0], vals[i]);
    end
    checks++;
    if (first_stall_accepts != 5) begin
      failures++;
      $display("FAIL b2b_first_stall: got %0d accepts before stall, want 5", first_stall_accepts);
    end
    wait_drained("b2b");
    checks++;
    if (rise_q.size() != 6) begin
      failures++;
      $display("FAIL b2b_writes: got %0d, want 6", rise_q.size());
    end
    check_pitch("b2b");
  endtask

  task automatic test_init_push();
    bit ok;
    reset = 1'b0;
    repeat (2) step();
    sb.delete();
    rise_q.delete();
    pre_done_rises = 0;
    push_init_expect();
    reset = 1'b1;
    push_byte(1'b1, 8'hA5);
    push_byte(1'b0, 8'h2A);
    wait_init_done(ok);
    wait_drained("init_push");
    checks++;
    if (pre_done_rises != 5) begin
      failures++;
      $display("FAIL init_push_early: got %0d writes before init_done, want 5", pre_done_rises);
    end
    checks++;
    if (rise_q.size() != 7) begin
      failures++;
      $display("FAIL init_push_writes: got %0d, want 7", rise_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit low_seen;
    wait_drained("pre_mid");
    push_byte(1'b1, 8'h11);
    push_byte(1'b1, 8'h22);
    push_byte(1'b0, 8'h33);
    low_seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (wr === 1'b0) begin
        low_seen = 1'b1;
        break;
      end
      step();
    end
    checks++;
    if (!low_seen) begin
      failures++;
      $display("FAIL mid_low_timeout: got wr=%b, want 0", wr);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (wr !== 1'b1)       begin failures++; $display("FAIL mid_wr: got %b want 1", wr); end
    checks++; if (D !== 8'h00)       begin failures++; $display("FAIL mid_d: got %h want 00", D); end
    checks++; if (busy !== 1'b0)     begin failures++; $display("FAIL mid_busy: got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_in_ready: got %b want 0", in_ready); end
    sb.delete();
    rise_q.delete();
    push_init_expect();
    repeat (2) step();
    reset = 1'b1;
    wait_init_done(ok);
    repeat (30) step();
    checks++;
    if (rise_q.size() != 5 || sb.size() != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_replay: got writes=%0d pending=%0d busy=%b, want 5/0/0", rise_q.size(), sb.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_back_to_back();
    test_init_push();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
